// File: rtl/branch_operand_if.sv
// Branch operand bus: pipeline sources and comparator feedback in, operands/control/stats out.
interface branch_operand_if #(
   parameter int CNT_W = 16
);
   logic              id_beq;
   logic              id_bne;
   logic [4:0]        id_rs;
   logic [4:0]        id_rt;
   logic [31:0]       rf_rs_data;
   logic [31:0]       rf_rt_data;
   logic              ex_regwrite;
   logic              ex_memread;
   logic [4:0]        ex_rd;
   logic              mem_regwrite;
   logic              mem_memread;
   logic [4:0]        mem_rd;
   logic [31:0]       mem_alu_result;
   logic              wb_regwrite;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;
   logic              cmp_equal;
   logic [31:0]       cbd;
   logic [31:0]       cad;
   logic              stall;
   logic              br_taken;
   logic              flush_if;
   logic              stall_err;
   logic [CNT_W-1:0]  br_count;
   logic [CNT_W-1:0]  taken_count;
   logic [CNT_W-1:0]  stall_count;

   modport master (
      output id_beq, id_bne, id_rs, id_rt, rf_rs_data, rf_rt_data,
             ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_memread, mem_rd,
             mem_alu_result, wb_regwrite, wb_rd, wb_data, cmp_equal,
      input  cbd, cad, stall, br_taken, flush_if, stall_err,
             br_count, taken_count, stall_count
   );

   modport slave (
      input  id_beq, id_bne, id_rs, id_rt, rf_rs_data, rf_rt_data,
             ex_regwrite, ex_memread, ex_rd, mem_regwrite, mem_memread, mem_rd,
             mem_alu_result, wb_regwrite, wb_rd, wb_data, cmp_equal,
      output cbd, cad, stall, br_taken, flush_if, stall_err,
             br_count, taken_count, stall_count
   );
endinterface

// File: rtl/branch_operand_unit.sv
// ID-stage branch operand forwarding, hazard stall, beq/bne resolution and statistics.
module branch_operand_unit #(
   parameter int CNT_W     = 16,
   parameter int MAX_STALL = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   branch_operand_if.slave   bus
);
   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [2:0]       HOLD_ONE = 3'd1;
   localparam logic [2:0]       STALL_LIM = 3'(MAX_STALL);

   state_t           state_q, state_d;
   logic [2:0]       hold_cnt_q, hold_cnt_d;
   logic             stall_err_q, stall_err_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic             is_br, haz, resolve, taken;
   logic [31:0]      cbd, cad;

   function automatic logic src_hit(input logic [4:0] r, input logic [4:0] rs,
                                    input logic [4:0] rt);
      return (r != 5'd0) && ((r == rs) || (r == rt));
   endfunction

   // Non-load MEM results beat WB; loads in MEM are never forwarded (they stall instead).
   function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] rf,
                                       input logic mem_wr, input logic mem_ld,
                                       input logic [4:0] mem_rd, input logic [31:0] mem_val,
                                       input logic wb_wr, input logic [4:0] wb_rd,
                                       input logic [31:0] wb_val);
      if (r == 5'd0)                          return 32'd0;
      else if (mem_wr && !mem_ld && mem_rd == r) return mem_val;
      else if (wb_wr && wb_rd == r)           return wb_val;
      else                                    return rf;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   // Hazard detection, operand selection and same-cycle branch resolution.
   always_comb begin
      is_br   = bus.id_beq | bus.id_bne;
      haz     = is_br & ((bus.ex_regwrite & src_hit(bus.ex_rd, bus.id_rs, bus.id_rt))
                       | (bus.mem_regwrite & bus.mem_memread
                          & src_hit(bus.mem_rd, bus.id_rs, bus.id_rt)));
      resolve = is_br & ~haz;
      taken   = resolve & (bus.id_beq ? bus.cmp_equal : ~bus.cmp_equal);
      cbd     = fwd(bus.id_rs, bus.rf_rs_data, bus.mem_regwrite, bus.mem_memread,
                    bus.mem_rd, bus.mem_alu_result, bus.wb_regwrite, bus.wb_rd, bus.wb_data);
      cad     = fwd(bus.id_rt, bus.rf_rt_data, bus.mem_regwrite, bus.mem_memread,
                    bus.mem_rd, bus.mem_alu_result, bus.wb_regwrite, bus.wb_rd, bus.wb_data);
   end

   // Stall-tracking FSM: counts consecutive stall cycles of the branch held in ID.
   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = hold_cnt_q;
      stall_err_d = stall_err_q;
      case (state_q)
         IDLE: begin
            if (haz) begin
               state_d    = HOLD;
               hold_cnt_d = HOLD_ONE;
            end
         end
         HOLD: begin
            if (haz) begin
               hold_cnt_d = (&hold_cnt_q) ? hold_cnt_q : hold_cnt_q + HOLD_ONE;
            end else begin
               // Covers both a resolved branch and one that left ID unresolved.
               state_d    = IDLE;
               hold_cnt_d = 3'd0;
            end
         end
         default: begin
            state_d    = IDLE;
            hold_cnt_d = 3'd0;
         end
      endcase
      if (hold_cnt_d >= STALL_LIM) stall_err_d = 1'b1;
   end

   // Saturating statistics.
   always_comb begin
      br_cnt_d    = resolve ? sat_inc(br_cnt_q)    : br_cnt_q;
      taken_cnt_d = taken   ? sat_inc(taken_cnt_q) : taken_cnt_q;
      stall_cnt_d = haz     ? sat_inc(stall_cnt_q) : stall_cnt_q;
   end

   // State and statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         hold_cnt_q  <= 3'd0;
         stall_err_q <= 1'b0;
         br_cnt_q    <= '0;
         taken_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         hold_cnt_q  <= hold_cnt_d;
         stall_err_q <= stall_err_d;
         br_cnt_q    <= br_cnt_d;
         taken_cnt_q <= taken_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.cbd         = cbd;
   assign bus.cad         = cad;
   assign bus.stall       = haz;
   assign bus.br_taken    = taken;
   assign bus.flush_if    = taken;
   assign bus.stall_err   = stall_err_q;
   assign bus.br_count    = br_cnt_q;
   assign bus.taken_count = taken_cnt_q;
   assign bus.stall_count = stall_cnt_q;
endmodule

// File: tb/tb_branch_operand_unit.sv
// Scoreboard bench for branch_operand_unit (small counter width to reach saturation).
module tb_branch_operand_unit;
   localparam int CW = 6;
   localparam logic [CW-1:0] SAT = '1;

   typedef struct {
      logic        stall;
      logic        taken;
      logic [31:0] cbd;
      logic [31:0] cad;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   branch_operand_if #(.CNT_W(CW)) bus ();

   branch_operand_unit #(.CNT_W(CW), .MAX_STALL(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic idle_inputs();
      bus.id_beq = 0; bus.id_bne = 0; bus.id_rs = 0; bus.id_rt = 0;
      bus.rf_rs_data = 0; bus.rf_rt_data = 0;
      bus.ex_regwrite = 0; bus.ex_memread = 0; bus.ex_rd = 0;
      bus.mem_regwrite = 0; bus.mem_memread = 0; bus.mem_rd = 0; bus.mem_alu_result = 0;
      bus.wb_regwrite = 0; bus.wb_rd = 0; bus.wb_data = 0; bus.cmp_equal = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      // drive into HOLD with a hazard, then reset asynchronously mid-stall
      @(posedge clk); #1;
      bus.id_beq = 1; bus.id_rs = 5'd1; bus.ex_regwrite = 1; bus.ex_rd = 5'd1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; bus.id_beq = 0;
      #1;
      checks++;
      if (dut.state_q !== 1'b0 || dut.hold_cnt_q !== 3'd0 || bus.stall !== 1'b0 ||
          bus.br_taken !== 1'b0 || bus.flush_if !== 1'b0 || bus.stall_err !== 1'b0 ||
          bus.br_count !== '0 || bus.taken_count !== '0 || bus.stall_count !== '0) begin
         errors++;
         $display("FAIL reset_mid_hold: state=%b hold=%0d stall=%b taken=%b err=%b br=%0d tk=%0d st=%0d, want all 0",
                  dut.state_q, dut.hold_cnt_q, bus.stall, bus.br_taken, bus.stall_err,
                  bus.br_count, bus.taken_count, bus.stall_count);
      end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_beq_taken();
      exp_t e;
      do_reset();
      @(posedge clk); #1;
      bus.id_beq = 1; bus.id_rs = 5'd3; bus.id_rt = 5'd4;
      bus.rf_rs_data = 32'h10; bus.rf_rt_data = 32'h10; bus.cmp_equal = 1;
      sb.push_back('{stall: 1'b0, taken: 1'b1, cbd: 32'h10, cad: 32'h10});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (bus.stall !== e.stall || bus.br_taken !== e.taken || bus.flush_if !== e.taken ||
          bus.cbd !== e.cbd || bus.cad !== e.cad) begin
         errors++;
         $display("FAIL beq_taken: stall=%b taken=%b flush=%b cbd=%h cad=%h want %b %b %h %h",
                  bus.stall, bus.br_taken, bus.flush_if, bus.cbd, bus.cad,
                  e.stall, e.taken, e.cbd, e.cad);
      end
      @(posedge clk); #1 idle_inputs();
      checks++;
      if (bus.br_count !== CW'(1) || bus.taken_count !== CW'(1) || bus.stall_count !== '0) begin
         errors++;
         $display("FAIL beq_counts: br=%0d tk=%0d st=%0d want 1 1 0",
                  bus.br_count, bus.taken_count, bus.stall_count);
      end
   endtask

   task automatic test_bne_alu_fwd();
      exp_t e;
      do_reset();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         idle_inputs();
         bus.id_bne = 1; bus.id_rs = 5'd5; bus.id_rt = 5'd6;
         bus.rf_rs_data = 32'h99; bus.rf_rt_data = 32'h33;
         if (c == 0) begin
            bus.ex_regwrite = 1; bus.ex_rd = 5'd5; bus.cmp_equal = 1;
            sb.push_back('{stall: 1'b1, taken: 1'b0, cbd: 32'h99, cad: 32'h33});
         end else begin
            bus.mem_regwrite = 1; bus.mem_rd = 5'd5; bus.mem_alu_result = 32'h22;
            bus.cmp_equal = 0;
            sb.push_back('{stall: 1'b0, taken: 1'b1, cbd: 32'h22, cad: 32'h33});
         end
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (bus.stall !== e.stall || bus.br_taken !== e.taken || bus.flush_if !== e.taken ||
             bus.cbd !== e.cbd || bus.cad !== e.cad) begin
            errors++;
            $display("FAIL bne_alu cyc%0d: stall=%b taken=%b flush=%b cbd=%h cad=%h want %b %b %h %h",
                     c, bus.stall, bus.br_taken, bus.flush_if, bus.cbd, bus.cad,
                     e.stall, e.taken, e.cbd, e.cad);
         end
      end
      @(posedge clk); #1 idle_inputs();
      checks++;
      if (bus.stall_count !== CW'(1) || bus.br_count !== CW'(1) || bus.taken_count !== CW'(1)) begin
         errors++;
         $display("FAIL bne_counts: st=%0d br=%0d tk=%0d want 1 1 1",
                  bus.stall_count, bus.br_count, bus.taken_count);
      end
   endtask

   task automatic test_load_use();
      exp_t e;
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         idle_inputs();
         bus.id_beq = 1; bus.id_rs = 5'd8; bus.id_rt = 5'd7;
         bus.rf_rs_data = 32'h77; bus.rf_rt_data = 32'h11; bus.cmp_equal = 1;
         case (c)
            0: begin
               bus.ex_regwrite = 1; bus.ex_memread = 1; bus.ex_rd = 5'd7;
               sb.push_back('{stall: 1'b1, taken: 1'b0, cbd: 32'h77, cad: 32'h11});
            end
            1: begin
               bus.mem_regwrite = 1; bus.mem_memread = 1; bus.mem_rd = 5'd7;
               bus.mem_alu_result = 32'hBAD;
               sb.push_back('{stall: 1'b1, taken: 1'b0, cbd: 32'h77, cad: 32'h11});
            end
            default: begin
               bus.wb_regwrite = 1; bus.wb_rd = 5'd7; bus.wb_data = 32'h77;
               sb.push_back('{stall: 1'b0, taken: 1'b1, cbd: 32'h77, cad: 32'h77});
            end
         endcase
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (bus.stall !== e.stall || bus.br_taken !== e.taken || bus.flush_if !== e.taken ||
             bus.cbd !== e.cbd || bus.cad !== e.cad) begin
            errors++;
            $display("FAIL load_use cyc%0d: stall=%b taken=%b flush=%b cbd=%h cad=%h want %b %b %h %h",
                     c, bus.stall, bus.br_taken, bus.flush_if, bus.cbd, bus.cad,
                     e.stall, e.taken, e.cbd, e.cad);
         end
      end
      @(posedge clk); #1 idle_inputs();
      checks++;
      if (bus.stall_count !== CW'(2) || bus.br_count !== CW'(1) || bus.stall_err !== 1'b0) begin
         errors++;
         $display("FAIL load_counts: st=%0d br=%0d err=%b want 2 1 0",
                  bus.stall_count, bus.br_count, bus.stall_err);
      end
   endtask

   task automatic test_zero_and_priority();
      exp_t e;
      do_reset();
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #1;
         idle_inputs();
         bus.id_beq = 1; bus.id_rs = 5'd0; bus.id_rt = 5'd9;
         bus.rf_rs_data = 32'hDEAD; bus.rf_rt_data = 32'hCCCC; bus.cmp_equal = 0;
         bus.ex_regwrite = 1; bus.ex_rd = 5'd0;
         bus.wb_regwrite = 1; bus.wb_rd = 5'd9; bus.wb_data = 32'hBBBB;
         if (c == 0) begin
            bus.mem_regwrite = 1; bus.mem_rd = 5'd9; bus.mem_alu_result = 32'hAAAA;
            sb.push_back('{stall: 1'b0, taken: 1'b0, cbd: 32'h0, cad: 32'hAAAA});
         end else begin
            sb.push_back('{stall: 1'b0, taken: 1'b0, cbd: 32'h0, cad: 32'hBBBB});
         end
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if (bus.stall !== e.stall || bus.br_taken !== e.taken || bus.flush_if !== e.taken ||
             bus.cbd !== e.cbd || bus.cad !== e.cad) begin
            errors++;
            $display("FAIL zero_prio cyc%0d: stall=%b taken=%b flush=%b cbd=%h cad=%h want %b %b %h %h",
                     c, bus.stall, bus.br_taken, bus.flush_if, bus.cbd, bus.cad,
                     e.stall, e.taken, e.cbd, e.cad);
         end
      end
      @(posedge clk); #1 idle_inputs();
      checks++;
      if (bus.br_count !== CW'(2) || bus.taken_count !== '0 || bus.stall_count !== '0) begin
         errors++;
         $display("FAIL zero_counts: br=%0d tk=%0d st=%0d want 2 0 0",
                  bus.br_count, bus.taken_count, bus.stall_count);
      end
   endtask

   task automatic test_stall_err();
      do_reset();
      @(posedge clk); #1;
      bus.id_beq = 1; bus.id_rs = 5'd2; bus.ex_regwrite = 1; bus.ex_rd = 5'd2;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (bus.stall_err !== 1'b0 || dut.hold_cnt_q !== 3'd2) begin
         errors++;
         $display("FAIL stall_err_early: err=%b hold=%0d want 0 2", bus.stall_err, dut.hold_cnt_q);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.stall_err !== 1'b1) begin
         errors++;
         $display("FAIL stall_err_set: err=%b want 1", bus.stall_err);
      end
      // branch leaves ID unresolved
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.stall_err !== 1'b1 || dut.state_q !== 1'b0 || dut.hold_cnt_q !== 3'd0 ||
          bus.stall_count !== CW'(3) || bus.br_count !== '0) begin
         errors++;
         $display("FAIL stall_err_sticky: err=%b state=%b hold=%0d st=%0d br=%0d want 1 0 0 3 0",
                  bus.stall_err, dut.state_q, dut.hold_cnt_q, bus.stall_count, bus.br_count);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      @(posedge clk); #1;
      bus.id_beq = 1; bus.id_rs = 5'd2; bus.ex_regwrite = 1; bus.ex_rd = 5'd2;
      repeat (70) @(posedge clk);
      #1;
      checks++;
      if (bus.stall_count !== SAT || dut.hold_cnt_q !== 3'd7 || bus.stall !== 1'b1) begin
         errors++;
         $display("FAIL sat_stall: st=%0d hold=%0d stall=%b want %0d 7 1",
                  bus.stall_count, dut.hold_cnt_q, bus.stall, SAT);
      end
      bus.ex_regwrite = 0; bus.cmp_equal = 1;
      repeat (70) @(posedge clk);
      #1;
      checks++;
      if (bus.br_count !== SAT || bus.taken_count !== SAT || bus.stall_count !== SAT ||
          bus.stall_err !== 1'b1) begin
         errors++;
         $display("FAIL sat_counts: br=%0d tk=%0d st=%0d err=%b want %0d %0d %0d 1",
                  bus.br_count, bus.taken_count, bus.stall_count, bus.stall_err, SAT, SAT, SAT);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      #2;
      checks++;
      if (bus.stall !== 1'b0 || bus.br_taken !== 1'b0 || bus.br_count !== '0 ||
          bus.stall_err !== 1'b0) begin
         errors++;
         $display("FAIL power_on_reset: stall=%b taken=%b br=%0d err=%b want 0 0 0 0",
                  bus.stall, bus.br_taken, bus.br_count, bus.stall_err);
      end
      test_reset();
      test_beq_taken();
      test_bne_alu_fwd();
      test_load_use();
      test_zero_and_priority();
      test_stall_err();
      test_saturation();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
